// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port data-RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int MAXBURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Burst counter width; a single-grant burst still needs one bit.
  function automatic int cnt_width(input int maxburst);
    return (maxburst > 1) ? $clog2(maxburst) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Two-way pick: favours the last owner while holding, otherwise the other port.
module ram_port_arbiter_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       hold,
  input  logic       force_switch,
  output logic [1:0] gnt
);

  logic fav;

  always_comb begin
    fav = (hold && !force_switch) ? last : !last;
    gnt = 2'b00;
    if (!fav) begin
      if (req0)      gnt = 2'b01;
      else if (req1) gnt = 2'b10;
    end else begin
      if (req1)      gnt = 2'b10;
      else if (req0) gnt = 2'b01;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between core (0) and loader (1).
//   state | meaning
//   IDLE  | no grant last cycle; ties go to the port that was not granted last
//   OWN0  | port 0 granted last cycle, keeps bus until it drops or burst limit hit
//   OWN1  | port 1 granted last cycle, keeps bus until it drops or burst limit hit
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_enw,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam int              CNT_W    = cnt_width(MAXBURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXBURST - 1);

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic       hold, other_req, force_switch;
  logic [1:0] gnt_pick;

  assign hold         = (state_q != IDLE);
  assign other_req    = last_q ? req0 : req1;
  assign force_switch = hold && other_req && (cnt_q == CNT_LAST);

  ram_port_arbiter_rr_pick u_pick (
    .req0         (req0),
    .req1         (req1),
    .last         (last_q),
    .hold         (hold),
    .force_switch (force_switch),
    .gnt          (gnt_pick)
  );

  always_comb begin
    gnt0      = nreset && gnt_pick[0];
    gnt1      = nreset && gnt_pick[1];
    state_d   = IDLE;
    last_d    = last_q;
    cnt_d     = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_enw   = 1'b0;
    if (gnt0) begin
      state_d   = OWN0;
      last_d    = 1'b0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_enw   = we0;
      if (state_q == OWN0) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end else if (gnt1) begin
      state_d   = OWN1;
      last_d    = 1'b1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_enw   = we1;
      if (state_q == OWN1) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    // Read data is captured on the grant edge and held until that port's next read.
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? ram_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? ram_rdata : rdata1_q;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
